// File: rtl/product_accumulator.sv
// Saturating dot-product accumulator: sums LEN signed products from the upstream
// multiplier and presents the result over a valid/ready handshake.
module product_accumulator #(
  parameter int unsigned N     = 5,
  parameter int unsigned ACC_W = 16,
  parameter int unsigned LEN   = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2*N-1:0]          product,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_sum,
  output logic                    out_ovf
);

  typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

  localparam logic [ACC_W-1:0] MaxVal = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] MinVal = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [7:0]       LenCnt = 8'(LEN);

  state_e                  state_q;
  logic [ACC_W-1:0]        acc_q;
  logic [7:0]              cnt_q;
  logic                    ovf_q;
  logic                    in_ready_q;
  logic                    out_valid_q;
  logic signed [ACC_W-1:0] out_sum_q;
  logic                    out_ovf_q;

  logic [ACC_W:0]   sum_wide;
  logic [ACC_W-1:0] acc_next;
  logic             clamp;
  logic             accept;
  logic             last;

  // One guard bit is enough: a disagreeing top pair of bits means the true sum left the range.
  always_comb begin
    sum_wide = {acc_q[ACC_W-1], acc_q} + {{(ACC_W+1-2*N){product[2*N-1]}}, product};
    clamp    = sum_wide[ACC_W] != sum_wide[ACC_W-1];
    acc_next = sum_wide[ACC_W-1:0];
    if (clamp) acc_next = sum_wide[ACC_W] ? MinVal : MaxVal;
    accept   = in_valid && in_ready_q;
    last     = (cnt_q + 8'd1) == LenCnt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_ovf_q   <= 1'b0;
    end else if (clear) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StAccum: begin
          in_ready_q <= 1'b1;
          if (accept) begin
            acc_q <= acc_next;
            cnt_q <= cnt_q + 8'd1;
            ovf_q <= ovf_q | clamp;
            if (last) begin
              state_q     <= StDone;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
              out_sum_q   <= acc_next;
              out_ovf_q   <= ovf_q | clamp;
            end else begin
              state_q <= StAccum;
            end
          end
        end
        StDone: begin
          if (out_ready) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: three parameterisations driven by directed and random
// sums, checked against a saturating-fold reference model.
module tb_product_accumulator;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic       in_valid [3];
  logic       out_ready [3];
  logic [9:0] prod [3];
  logic       in_ready [3];
  logic       out_valid [3];
  logic       ovf [3];
  logic signed [9:0]  sum0;
  logic signed [9:0]  sum1;
  logic signed [15:0] sum2;

  int nvec = 0;
  int nerr = 0;
  int pq[$];

  localparam int LenOf [3] = '{4, 2, 4};
  localparam int WOf [3]   = '{10, 10, 16};

  always #5 clk = ~clk;

  product_accumulator #(.N(5), .ACC_W(10), .LEN(4)) u_d0 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .product(prod[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_sum(sum0),
    .out_ovf(ovf[0])
  );
  product_accumulator #(.N(5), .ACC_W(10), .LEN(2)) u_d1 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .product(prod[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_sum(sum1),
    .out_ovf(ovf[1])
  );
  product_accumulator u_d2 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .product(prod[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_sum(sum2),
    .out_ovf(ovf[2])
  );

  initial begin
    #300000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [31:0] get_sum(input int d);
    logic signed [31:0] r;
    case (d)
      0:       r = sum0;
      1:       r = sum1;
      default: r = sum2;
    endcase
    return r;
  endfunction

  // Reference: saturating fold of pq within a w-bit signed range.
  task automatic model(input int w, output int s, output int o);
    int hi = (1 << (w - 1)) - 1;
    int lo = -(1 << (w - 1));
    s = 0;
    o = 0;
    foreach (pq[i]) begin
      s = s + pq[i];
      if (s > hi) begin s = hi; o = 1; end
      if (s < lo) begin s = lo; o = 1; end
    end
  endtask

  task automatic idle_all();
    for (int i = 0; i < 3; i++) begin
      in_valid[i]  = 1'b0;
      out_ready[i] = 1'b0;
      prod[i]      = '0;
    end
  endtask

  // Feeds pq into instance d, holds the result for `hold` cycles, then transfers it
  // (or aborts it with clear when abort is set).
  task automatic run_sum(input int d, input int hold, input int gap_max, input bit abort);
    int es, eo, pv;
    model(WOf[d], es, eo);
    foreach (pq[i]) begin
      repeat ($urandom_range(0, gap_max)) begin
        @(negedge clk);
        in_valid[d] = 1'b0;
        chk("gap_in_ready", 32'(in_ready[d]), 1);
      end
      @(negedge clk);
      pv = pq[i];
      in_valid[d] = 1'b1;
      prod[d] = pv[9:0];
      chk("busy_in_ready", 32'(in_ready[d]), 1);
      chk("busy_out_valid", 32'(out_valid[d]), 0);
    end
    @(negedge clk);
    in_valid[d] = 1'b0;
    chk("done_out_valid", 32'(out_valid[d]), 1);
    chk("done_in_ready", 32'(in_ready[d]), 0);
    chk("done_sum", get_sum(d), es);
    chk("done_ovf", 32'(ovf[d]), eo);
    for (int h = 0; h < hold; h++) begin
      in_valid[d] = 1'b1;
      prod[d] = 10'($urandom_range(0, 1023));
      @(negedge clk);
      chk("hold_sum", get_sum(d), es);
      chk("hold_ovf", 32'(ovf[d]), eo);
      chk("hold_in_ready", 32'(in_ready[d]), 0);
      chk("hold_out_valid", 32'(out_valid[d]), 1);
    end
    in_valid[d] = 1'b0;
    if (abort) clear = 1'b1;
    else out_ready[d] = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    out_ready[d] = 1'b0;
    chk("after_out_valid", 32'(out_valid[d]), 0);
    chk("after_in_ready", 32'(in_ready[d]), 1);
    chk("after_sum_held", get_sum(d), es);
  endtask

  initial begin
    int p;
    idle_all();
    #1;
    chk("rst_sum", get_sum(0), 0);
    chk("rst_ovf", 32'(ovf[0]), 0);
    chk("rst_out_valid", 32'(out_valid[0]), 0);
    chk("rst_in_ready", 32'(in_ready[0]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rel_in_ready", 32'(in_ready[0]), 0);
    @(negedge clk);
    chk("first_in_ready", 32'(in_ready[0]), 1);

    pq = '{8, 15, 11, -3};
    run_sum(0, 0, 0, 1'b0);
    run_sum(0, 5, 0, 1'b0);
    run_sum(2, 1, 0, 1'b0);
    pq = '{256, 256, -16, -16};
    run_sum(0, 0, 0, 1'b0);
    pq = '{-512, -256};
    run_sum(1, 0, 0, 1'b0);
    pq = '{1, 2};
    run_sum(1, 0, 0, 1'b0);

    // Abort after two products; the product presented alongside clear must be dropped.
    @(negedge clk);
    in_valid[0] = 1'b1;
    prod[0] = 10'd7;
    @(negedge clk);
    prod[0] = 10'd9;
    @(negedge clk);
    clear = 1'b1;
    prod[0] = 10'd100;
    @(negedge clk);
    clear = 1'b0;
    in_valid[0] = 1'b0;
    chk("clr_out_valid", 32'(out_valid[0]), 0);
    chk("clr_in_ready", 32'(in_ready[0]), 1);
    pq = '{1, 1, 1, 1};
    run_sum(0, 0, 1, 1'b0);
    pq = '{1, 2, 3, 4};
    run_sum(0, 2, 0, 1'b1);

    // Asynchronous reset in the middle of a sum.
    @(negedge clk);
    in_valid[0] = 1'b1;
    prod[0] = 10'd5;
    @(negedge clk);
    prod[0] = 10'd6;
    @(negedge clk);
    in_valid[0] = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_sum", get_sum(0), 0);
    chk("arst_ovf", 32'(ovf[0]), 0);
    chk("arst_out_valid", 32'(out_valid[0]), 0);
    chk("arst_in_ready", 32'(in_ready[0]), 0);
    #3;
    rst_n = 1'b1;
    #1;
    chk("arst_rel_in_ready", 32'(in_ready[0]), 0);
    pq = '{2, 2, 2, 2};
    run_sum(0, 0, 0, 1'b0);

    for (int r = 0; r < 60; r++) begin
      int d = $urandom_range(0, 2);
      pq = {};
      for (int k = 0; k < LenOf[d]; k++) begin
        case ($urandom_range(0, 3))
          0:       p = ($urandom_range(0, 1) != 0) ? 511 : -512;
          1:       p = $urandom_range(0, 40) - 20;
          default: p = $urandom_range(0, 1023) - 512;
        endcase
        pq.push_back(p);
      end
      run_sum(d, $urandom_range(0, 3), 2, ($urandom_range(0, 7) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
